// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared constants, state encoding and golden truth table for the gate self-test
package gate_test_pkg;
    localparam int NUM_VECTORS = 4;
    localparam int AND_BIT  = 0;
    localparam int OR_BIT   = 1;
    localparam int NOT_BIT  = 2;
    localparam int NAND_BIT = 3;
    localparam int NOR_BIT  = 4;
    localparam int XOR_BIT  = 5;
    localparam int XNOR_BIT = 6;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    function automatic logic [6:0] expected(input logic [1:0] v);
        logic [6:0] e;
        e           = '0;
        e[AND_BIT]  = v[1] & v[0];
        e[OR_BIT]   = v[1] | v[0];
        e[NOT_BIT]  = ~v[1];
        e[NAND_BIT] = ~(v[1] & v[0]);
        e[NOR_BIT]  = ~(v[1] | v[0]);
        e[XOR_BIT]  = v[1] ^ v[0];
        e[XNOR_BIT] = ~(v[1] ^ v[0]);
        return e;
    endfunction
endpackage

// File: rtl/gate_self_test.sv
// gate_self_test: walks the gate block through all input vectors and checks its outputs
module gate_self_test
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] gate_out,
    input  logic [1:0] rd_idx,
    output logic [6:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);
    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] acc, acc_n;
    logic [6:0] cap [NUM_VECTORS];
    logic       mism;

    assign mism    = gate_out != expected(idx);
    assign rd_data = cap[rd_idx];

    // next-state logic; acc gathers mismatches privately so fail_mask/pass only move with done
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        acc_n   = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DRIVE;
                    idx_n   = '0;
                    cnt_n   = '0;
                    acc_n   = '0;
                end
            end
            DRIVE: begin
                cnt_n = cnt + 4'd1;
                if (cnt == 4'(SETTLE_CYCLES - 1)) state_n = SAMPLE;
            end
            SAMPLE: begin
                acc_n[idx] = acc[idx] | mism;
                if (idx == 2'd3) state_n = FINISH;
                else begin
                    idx_n   = idx + 2'd1;
                    cnt_n   = '0;
                    state_n = DRIVE;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs, all loaded from next-state values so they align with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            acc       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            a     <= (state_n == IDLE) ? 1'b0 : idx_n[1];
            b     <= (state_n == IDLE) ? 1'b0 : idx_n[0];
            busy  <= state_n != IDLE;
            done  <= state_n == FINISH;
            if (state == IDLE && start) begin
                pass      <= 1'b0;
                fail_mask <= '0;
            end
            if (state == SAMPLE && idx == 2'd3) begin
                pass      <= acc_n == 4'd0;
                fail_mask <= acc_n;
            end
        end
    end

    // capture registers keep the last observed outputs per vector across runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VECTORS; i++) cap[i] <= '0;
        end else if (state == SAMPLE) begin
            cap[idx] <= gate_out;
        end
    end
endmodule

// File: tb/tb_gate_self_test.sv
// tb_gate_self_test: directed checks of the gate self-test sequencer against a modelled gate block
module tb_gate_self_test;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic       a1, b1, a2, b2;
    logic [6:0] gate_out1, gate_out2;
    logic [1:0] rd_idx1 = 2'd0, rd_idx2 = 2'd0;
    logic [6:0] rd_data1, rd_data2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [3:0] fail_mask1, fail_mask2;
    int         fault = 0;
    logic [6:0] d1 = '0, d2 = '0;

    int         checks = 0, passed = 0;
    int         n_done, first_done, second_done;
    logic [1:0] ab_log [41];
    logic       busy_log [41];

    always #5 clk = ~clk;

    function automatic logic [6:0] gates(input logic x, input logic y);
        return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
    endfunction

    // healthy gate block with optional stuck-at faults
    assign gate_out1 = fault == 1 ? gates(a1, b1) & 7'h7E :
                       fault == 2 ? gates(a1, b1) | 7'h20 : gates(a1, b1);

    // slow gate block: output lags inputs by two cycles and starts each run empty
    always @(posedge clk) begin
        if (!busy2) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= gates(a2, b2);
            d2 <= d1;
        end
    end
    assign gate_out2 = d2;

    gate_self_test #(.SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .gate_out(gate_out1),
        .rd_idx(rd_idx1), .rd_data(rd_data1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_mask(fail_mask1)
    );

    gate_self_test #(.SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .gate_out(gate_out2),
        .rd_idx(rd_idx2), .rd_data(rd_data2), .busy(busy2), .done(done2),
        .pass(pass2), .fail_mask(fail_mask2)
    );

    task automatic run1(input bit hold, input int repulse);
        n_done = 0;
        first_done = -1;
        second_done = -1;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!hold) start1 = (c == repulse);
            ab_log[c] = {a1, b1};
            busy_log[c] = busy1;
            if (done1) begin
                n_done++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        start1 = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] rd_exp [4];
        rd_exp = '{7'h00, 7'h00, 7'h00, 7'h00};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a1, b1, busy1, done1, pass1, fail_mask1} !== 9'd0) $display("FAIL reset_outputs: got %b required 0", {a1, b1, busy1, done1, pass1, fail_mask1});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            rd_idx1 = 2'(i);
            #1;
            checks++;
            if (rd_data1 !== rd_exp[i]) $display("FAIL reset_capture%0d: got %h required %h", i, rd_data1, rd_exp[i]);
            else passed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int         cyc [7];
        logic [1:0] ab_exp [7];
        logic [6:0] rd_exp [4];
        cyc    = '{1, 3, 4, 7, 10, 13, 14};
        ab_exp = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
        rd_exp = '{7'h5C, 7'h2E, 7'h2A, 7'h43};
        fault = 0;
        run1(1'b0, 0);
        checks++;
        if (first_done !== 13) $display("FAIL nominal_done_cycle: got %0d required 13", first_done);
        else passed++;
        checks++;
        if (n_done !== 1) $display("FAIL nominal_done_count: got %0d required 1", n_done);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ab_log[cyc[i]] !== ab_exp[i]) $display("FAIL nominal_ab_c%0d: got %b required %b", cyc[i], ab_log[cyc[i]], ab_exp[i]);
            else passed++;
        end
        checks++;
        if ({busy_log[1], busy_log[13], busy_log[14]} !== 3'b110) $display("FAIL nominal_busy: got %b required 110", {busy_log[1], busy_log[13], busy_log[14]});
        else passed++;
        checks++;
        if ({pass1, fail_mask1} !== 5'b1_0000) $display("FAIL nominal_result: got pass=%b mask=%b required pass=1 mask=0000", pass1, fail_mask1);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            rd_idx1 = 2'(i);
            #1;
            checks++;
            if (rd_data1 !== rd_exp[i]) $display("FAIL nominal_capture%0d: got %h required %h", i, rd_data1, rd_exp[i]);
            else passed++;
        end
    endtask

    task automatic test_stuck_and0();
        fault = 1;
        run1(1'b0, 0);
        fault = 0;
        checks++;
        if ({pass1, fail_mask1} !== 5'b0_1000) $display("FAIL and0_result: got pass=%b mask=%b required pass=0 mask=1000", pass1, fail_mask1);
        else passed++;
        rd_idx1 = 2'd3;
        #1;
        checks++;
        if (rd_data1 !== 7'h42) $display("FAIL and0_capture3: got %h required 42", rd_data1);
        else passed++;
        rd_idx1 = 2'd1;
        #1;
        checks++;
        if (rd_data1 !== 7'h2E) $display("FAIL and0_capture1: got %h required 2e", rd_data1);
        else passed++;
    endtask

    task automatic test_stuck_xor1();
        logic [6:0] rd_exp [4];
        rd_exp = '{7'h7C, 7'h2E, 7'h2A, 7'h63};
        fault = 2;
        run1(1'b0, 0);
        fault = 0;
        checks++;
        if ({pass1, fail_mask1} !== 5'b0_1001) $display("FAIL xor1_result: got pass=%b mask=%b required pass=0 mask=1001", pass1, fail_mask1);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            rd_idx1 = 2'(i);
            #1;
            checks++;
            if (rd_data1 !== rd_exp[i]) $display("FAIL xor1_capture%0d: got %h required %h", i, rd_data1, rd_exp[i]);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        fault = 0;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        checks++;
        if ({a1, b1, busy1} !== 3'b101) $display("FAIL midrst_pre: got ab=%b busy=%b required ab=10 busy=1", {a1, b1}, busy1);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if ({a1, b1, busy1, done1, pass1, fail_mask1} !== 9'd0) $display("FAIL midrst_outputs: got %b required 0", {a1, b1, busy1, done1, pass1, fail_mask1});
        else passed++;
        rd_idx1 = 2'd0;
        #1;
        checks++;
        if (rd_data1 !== 7'h00) $display("FAIL midrst_capture0: got %h required 00", rd_data1);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done1) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL midrst_no_done: got %0d pulses required 0", seen);
        else passed++;
        run1(1'b0, 0);
        checks++;
        if ({first_done == 13, pass1, fail_mask1} !== 6'b11_0000) $display("FAIL midrst_rerun: got done_at=%0d pass=%b mask=%b required 13 1 0000", first_done, pass1, fail_mask1);
        else passed++;
    endtask

    task automatic test_busy_restart();
        run1(1'b0, 5);
        checks++;
        if (first_done !== 13 || n_done !== 1) $display("FAIL busy_restart: got done_at=%0d count=%0d required 13 1", first_done, n_done);
        else passed++;
    endtask

    task automatic test_back_to_back();
        run1(1'b1, 0);
        checks++;
        if (first_done !== 13 || second_done !== 27) $display("FAIL back_to_back: got %0d,%0d required 13,27", first_done, second_done);
        else passed++;
        checks++;
        if (pass1 !== 1'b1) $display("FAIL back_to_back_pass: got %b required 1", pass1);
        else passed++;
    endtask

    task automatic test_settle1();
        int done_at = -1;
        @(negedge clk);
        start2 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2 && done_at < 0) done_at = c;
        end
        checks++;
        if (done_at !== 9) $display("FAIL settle1_done_cycle: got %0d required 9", done_at);
        else passed++;
        checks++;
        if ({pass2, fail_mask2} !== 5'b0_1111) $display("FAIL settle1_result: got pass=%b mask=%b required pass=0 mask=1111", pass2, fail_mask2);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stuck_and0();
        test_stuck_xor1();
        test_mid_reset();
        test_busy_restart();
        test_back_to_back();
        test_settle1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/gate_self_test.md
# gate_self_test

Built-in self-test sequencer that sits directly upstream and downstream of the two-input primitive-gate block. It drives the gate block's `a`/`b` inputs through all four input combinations and waits a programmable settle time. It then captures the seven gate outputs per vector and compares them against a golden truth table, reporting a per-vector fail mask and an overall pass flag.

## Interface
- Clocking: one clock; reset is asynchronous and active-high. Ports are `clk` and `rst`.
- `SETTLE_CYCLES`, default 2, cycles inputs are held before sampling; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a test run; sampled only in IDLE.
- `a`  out  1  gate-block input a.
- `b`  out  1  gate-block input b.
- `gate_out`  in  7  gate-block outputs, packed as {xnor, xor, nor, nand, not, or, and} (bit 0 = and).
- `rd_idx`  in  2  vector index for capture readback.
- `rd_data`  out  7  captured `gate_out` for vector `rd_idx`; combinational read.
- `busy`  out  1  run in progress.
- `done`  out  1  single-cycle pulse at end of run.
- `pass`  out  1  last run had zero mismatches; held until the next start.
- `fail_mask`  out  4  bit v set if vector v mismatched; held until the next start.

## Operation
- Vector v = {a,b}, visited in order v0=00, v1=01, v2=10, v3=11.
- Golden `gate_out` per vector:
  - v0 = 7'h5C
  - v1 = 7'h2E
  - v2 = 7'h2A
  - v3 = 7'h43
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - `a` = `b` = 0, `busy` = 0.
  - `start` = 1 moves to DRIVE, with vector index = 0, settle count = 0, `fail_mask` cleared, `pass` cleared.
- DRIVE:
  - `a`,`b` are driven from the vector index.
  - Settle count increments each cycle; moves to SAMPLE when count = SETTLE_CYCLES-1.
- SAMPLE (one cycle):
  - Capture `gate_out` into capture register [index].
  - Set `fail_mask`[index] if the capture differs from golden.
  - If index = 3, go to FINISH. Otherwise increment index, clear count and return to DRIVE.
- FINISH (one cycle):
  - `done` = 1.
  - `pass` = (`fail_mask` == 0), computed including the final vector's compare result.
  - Next state is IDLE.
- `start` is ignored outside IDLE; no queuing.
- `a`/`b` remain at 11 through FINISH, then return to 00 in IDLE.
- Capture registers persist across runs and are overwritten only by the corresponding SAMPLE.
- Reset, including mid-run: state IDLE, `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, captures = 0, counters = 0. A run interrupted by reset produces no `done`.

## Timing
- All outputs except `rd_data` are registered.
- Edge E0 samples `start`; DRIVE begins in the cycle after E0.
- Each vector occupies SETTLE_CYCLES + 1 cycles.
- `done` is high during cycle 4*(SETTLE_CYCLES+1)+1 after E0. For the default, that is 13 cycles after E0.
- `busy` is high from the first DRIVE cycle through FINISH inclusive.
- `pass` and `fail_mask` update together with `done`: `pass` is valid in the `done` cycle.
- `start` held high continuously starts a new run in the cycle after `done`, which is the first IDLE cycle.
- The external gate block is combinational. `gate_out` must be stable within SETTLE_CYCLES cycles of `a`/`b` changing.

## Structure
- Package `gate_test_pkg` holds:
  - `NUM_VECTORS` = 4;
  - bit-index constants for the `gate_out` packing (AND=0 … XNOR=6);
  - FSM state enum;
  - golden function or constant array `expected(v)`.
- A single flat module. The settle counter and FSM are small enough that no sub-module is warranted.

## Test plan
- Correct gate block, SETTLE_CYCLES=2, pulse `start`:
  - `a`/`b` step 00→01→10→11;
  - `done` pulses 13 cycles after the `start` edge;
  - `pass`=1, `fail_mask`=0;
  - `rd_data` for `rd_idx` 0..3 = 5C, 2E, 2A, 43.
- Fault injection: force `gate_out` bit 0 (and) stuck at 0 → `pass`=0, `fail_mask`=4'b1000, `rd_data`[3] = 7'h42.
- Stuck-at-1 fault on the xor bit → `fail_mask`=4'b1001; v1 and v2 are unaffected.
- Assert `rst` mid-run during DRIVE of v2:
  - all outputs return to their reset values at once and no `done` pulse appears;
  - a subsequent `start` completes normally with `pass`=1.
- `start` pulsed again while `busy`=1 → ignored; the total run length is unchanged.
- SETTLE_CYCLES=1: `done` arrives 9 cycles after `start`. `gate_out` delayed by 2 cycles via bench pipeline → every vector mismatches, `fail_mask`=4'b1111.
